code_entry_lock: RTL and testbench
==================================

// Module: code_entry_lock
// PURPOSE
//  Combination-lock controller fed by the per-button debouncers; it consumes their one-cycle press pulses.
//  Collects a key sequence, compares it with a switch-programmed code on ENTER, and drives unlock/alarm.
//  Counts failed attempts and enforces a timed lockout. Sits between the debouncer bank and the LED/display logic.
// PARAMETERS
//  NUM_KEYS    4     number of digit buttons; key i encodes digit value i
//  KEY_W       2     bits per stored digit, >= clog2(NUM_KEYS)
//  CODE_LEN    4     digits per code
//  TIMEOUT_CYC 1000  idle cycles in ENTRY before the buffer is discarded
//  UNLOCK_CYC  2000  cycles unlocked stays high after a match
//  MAX_TRIES   3     consecutive mismatches before lockout
//  LOCKOUT_CYC 5000  lockout duration in cycles
// PORTS
//  clk          in   1                  clock
//  reset        in   1                  synchronous, active-high
//  key_pulse    in   NUM_KEYS           one-cycle debounced digit presses
//  enter_pulse  in   1                  one-cycle debounced ENTER press
//  clear_pulse  in   1                  one-cycle debounced CLEAR press
//  code_in      in   CODE_LEN*KEY_W     programmed code; digit 0 in [KEY_W-1:0]
//  unlocked     out  1                  high while in UNLOCK
//  bad_code     out  1                  one-cycle pulse on a non-final mismatch
//  alarm        out  1                  high while in LOCKOUT
//  digit_count  out  clog2(CODE_LEN+1)  digits currently buffered
//  tries_left   out  clog2(MAX_TRIES+1) remaining attempts
// BEHAVIOUR
//  Reset: state IDLE, buffer zeroed, digit_count=0, tries_left=MAX_TRIES; unlocked/bad_code/alarm=0.
//  States: IDLE, ENTRY, CHECK, UNLOCK, FAIL, LOCKOUT; one-hot outputs registered from state.
//  Valid key: exactly one bit of key_pulse set; multi-bit or zero -> no key event.
//  IDLE: valid key -> store digit in slot 0, digit_count=1, go ENTRY. enter/clear ignored.
//  ENTRY: valid key stored at slot digit_count, digit_count+1; once digit_count==CODE_LEN,
//    further keys set a sticky overrun flag, buffer unchanged.
//  ENTRY: clear_pulse -> buffer, count and overrun cleared, go IDLE, tries unchanged.
//  ENTRY: idle timer reloads on any key/clear event; reaching TIMEOUT_CYC -> same as clear.
//  Simultaneous events: enter beats clear beats key; the losing pulses are dropped.
//  ENTRY + enter_pulse at cycle t -> CHECK at t+1. code_in is sampled in CHECK.
//  Match iff digit_count==CODE_LEN, no overrun, and buffer==code_in.
//  CHECK match -> UNLOCK at t+2. unlocked=1 for UNLOCK_CYC cycles; tries_left=MAX_TRIES.
//  CHECK mismatch, tries_left>1 -> tries_left-1, FAIL at t+2 (bad_code=1 one cycle), then IDLE.
//  CHECK mismatch, tries_left==1 -> tries_left=0, LOCKOUT at t+2, alarm=1 for LOCKOUT_CYC cycles.
//  LOCKOUT: all inputs ignored; at expiry go IDLE with tries_left=MAX_TRIES.
//  UNLOCK: keys/enter ignored; clear_pulse re-locks immediately (next cycle IDLE); otherwise IDLE at expiry.
//  Leaving CHECK/FAIL/UNLOCK/LOCKOUT always clears buffer, digit_count and overrun.
//  Timers: down-counters that saturate at 0, no wrap. Counter width is clog2 of the largest *_CYC.
//  reset asserted in any state, mid-timer included, gives the reset values on the next edge.
// STRUCTURE
//  Package lock_pkg holds the state enum, the lock_state_t typedef and the default timing constants.
//  Sub-module cycle_timer (load, count, done) is shared sequentially for the timeout, unlock and lockout timers.
//  Only one timer is ever active per state.
//  Digit buffer is a flat CODE_LEN*KEY_W register with an indexed write.
// TESTING (CODE_LEN=4, TIMEOUT_CYC=20, UNLOCK_CYC=10, LOCKOUT_CYC=30, MAX_TRIES=3, code_in=8'b11_10_01_00)
//  Keys 0,1,2,3 then enter -> unlocked high 2 cycles after enter, for exactly 10 cycles; tries_left=3.
//  Keys 0,1,2 then enter -> bad_code pulse; tries_left=2; then IDLE.
//  Key 0,1,2,3,3 then enter -> overrun mismatch, bad_code pulse.
//  Three wrong entries -> alarm=1 for 30 cycles; keys ignored during lockout.
//    After expiry: tries_left=3, and the correct code unlocks.
//  Key 0 then 20 idle cycles -> digit_count=0 and state IDLE; key_pulse=4'b0011 leaves digit_count unchanged.
//  Same-cycle enter+key; reset pulsed mid-UNLOCK -> enter wins; reset drops unlocked=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared state type and default timing for the combination-lock controller.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_UNLOCK,
    ST_FAIL,
    ST_LOCKOUT
  } lock_state_t;

  localparam int DEF_TIMEOUT_CYC = 1000;
  localparam int DEF_UNLOCK_CYC  = 2000;
  localparam int DEF_LOCKOUT_CYC = 5000;
  localparam int DEF_MAX_TRIES   = 3;

  // One counter serves all three timers, so it is sized for the longest one.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Saturating down-counter shared by the entry timeout, unlock hold and lockout timers.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         count,
  output logic         done
);

  logic [W-1:0] value;

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (count && (value != '0)) begin
      value <= value - W'(1);
    end
  end

  assign done = (value == '0);

endmodule

// File: rtl/code_entry_lock.sv
// Combination-lock controller: buffers debounced key presses, checks them against the
// switch-programmed code on ENTER, and drives unlock, bad-code pulse and lockout alarm.
module code_entry_lock
  import lock_pkg::*;
#(
  parameter int NUM_KEYS    = 4,
  parameter int KEY_W       = 2,
  parameter int CODE_LEN    = 4,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int UNLOCK_CYC  = DEF_UNLOCK_CYC,
  parameter int MAX_TRIES   = DEF_MAX_TRIES,
  parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_KEYS-1:0]             key_pulse,
  input  logic                            enter_pulse,
  input  logic                            clear_pulse,
  input  logic [CODE_LEN*KEY_W-1:0]       code_in,
  output logic                            unlocked,
  output logic                            bad_code,
  output logic                            alarm,
  output logic [$clog2(CODE_LEN+1)-1:0]   digit_count,
  output logic [$clog2(MAX_TRIES+1)-1:0]  tries_left
);

  localparam int CNT_W = $clog2(CODE_LEN + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = timer_width(TIMEOUT_CYC, UNLOCK_CYC, LOCKOUT_CYC);
  localparam int BUF_W = CODE_LEN * KEY_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CODE_LEN);
  localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] UNL_LOAD = TMR_W'(UNLOCK_CYC - 1);
  localparam logic [TMR_W-1:0] LCK_LOAD = TMR_W'(LOCKOUT_CYC - 1);

  function automatic logic key_is_single(input logic [NUM_KEYS-1:0] k);
    return (k != '0) && ((k & (k - NUM_KEYS'(1))) == '0);
  endfunction

  function automatic logic [KEY_W-1:0] key_digit(input logic [NUM_KEYS-1:0] k);
    logic [KEY_W-1:0] d;
    d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (k[i]) d = KEY_W'(i);
    end
    return d;
  endfunction

  lock_state_t      state, next_state;
  logic [BUF_W-1:0] code_buf;
  logic             overrun;
  logic             key_ev, is_match;
  logic             unlocked_d, bad_code_d, alarm_d;
  logic             timer_load, timer_count, timer_done;
  logic [TMR_W-1:0] timer_value;

  assign key_ev   = key_is_single(key_pulse);
  assign is_match = (digit_count == FULL_CNT) && !overrun && (code_buf == code_in);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      unlocked <= 1'b0;
      bad_code <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      state    <= next_state;
      unlocked <= unlocked_d;
      bad_code <= bad_code_d;
      alarm    <= alarm_d;
    end
  end

  // Enter beats clear beats key; a timeout only acts on a cycle with no event.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (key_ev) next_state = ST_ENTRY;
      ST_ENTRY: begin
        if (enter_pulse)      next_state = ST_CHECK;
        else if (clear_pulse) next_state = ST_IDLE;
        else if (key_ev)      next_state = ST_ENTRY;
        else if (timer_done)  next_state = ST_IDLE;
      end
      ST_CHECK: begin
        if (is_match)                     next_state = ST_UNLOCK;
        else if (tries_left > TRY_W'(1))  next_state = ST_FAIL;
        else                              next_state = ST_LOCKOUT;
      end
      ST_FAIL:    next_state = ST_IDLE;
      ST_UNLOCK:  if (clear_pulse || timer_done) next_state = ST_IDLE;
      ST_LOCKOUT: if (timer_done) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    unlocked_d = (next_state == ST_UNLOCK);
    bad_code_d = (next_state == ST_FAIL);
    alarm_d    = (next_state == ST_LOCKOUT);
  end

  // Timer loads are CYC-1 so that done marks the last cycle of the interval.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = TMO_LOAD;
    if ((state == ST_CHECK) && (next_state == ST_UNLOCK)) begin
      timer_load  = 1'b1;
      timer_value = UNL_LOAD;
    end else if ((state == ST_CHECK) && (next_state == ST_LOCKOUT)) begin
      timer_load  = 1'b1;
      timer_value = LCK_LOAD;
    end else if ((next_state == ST_ENTRY) && ((state == ST_IDLE) || key_ev)) begin
      timer_load  = 1'b1;
    end
  end

  assign timer_count = (state == ST_ENTRY) || (state == ST_UNLOCK) || (state == ST_LOCKOUT);

  cycle_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .count      (timer_count),
    .done       (timer_done)
  );

  // Digit buffer, overrun flag and attempt counter
  always_ff @(posedge clk) begin
    if (reset) begin
      code_buf    <= '0;
      digit_count <= '0;
      overrun     <= 1'b0;
      tries_left  <= TRY_MAX;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (key_ev) begin
            code_buf[KEY_W-1:0] <= key_digit(key_pulse);
            digit_count         <= CNT_W'(1);
          end
        end
        ST_ENTRY: begin
          if (enter_pulse) begin
            code_buf <= code_buf;
          end else if (clear_pulse || (!key_ev && timer_done)) begin
            code_buf    <= '0;
            digit_count <= '0;
            overrun     <= 1'b0;
          end else if (key_ev) begin
            if (digit_count == FULL_CNT) begin
              overrun <= 1'b1;
            end else begin
              code_buf[int'(digit_count)*KEY_W +: KEY_W] <= key_digit(key_pulse);
              digit_count <= digit_count + CNT_W'(1);
            end
          end
        end
        ST_CHECK: begin
          code_buf    <= '0;
          digit_count <= '0;
          overrun     <= 1'b0;
          if (is_match)                    tries_left <= TRY_MAX;
          else if (tries_left > TRY_W'(1)) tries_left <= tries_left - TRY_W'(1);
          else                             tries_left <= '0;
        end
        ST_LOCKOUT: begin
          if (timer_done) tries_left <= TRY_MAX;
        end
        default: begin
          code_buf    <= '0;
          digit_count <= '0;
          overrun     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_entry_lock.sv
// Directed bench for code_entry_lock with a queue-based reference model checked every cycle.
module tb_code_entry_lock;

  localparam int NK = 4;
  localparam int KW = 2;
  localparam int CL = 4;
  localparam int TO = 20;
  localparam int UC = 10;
  localparam int MT = 3;
  localparam int LC = 30;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] key_pulse = '0;
  logic          enter_pulse = 1'b0;
  logic          clear_pulse = 1'b0;
  logic [CL*KW-1:0] code_in = 8'b11_10_01_00;
  logic          unlocked, bad_code, alarm;
  logic [2:0]    digit_count;
  logic [1:0]    tries_left;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  code_entry_lock #(
    .NUM_KEYS    (NK),
    .KEY_W       (KW),
    .CODE_LEN    (CL),
    .TIMEOUT_CYC (TO),
    .UNLOCK_CYC  (UC),
    .MAX_TRIES   (MT),
    .LOCKOUT_CYC (LC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_pulse   (key_pulse),
    .enter_pulse (enter_pulse),
    .clear_pulse (clear_pulse),
    .code_in     (code_in),
    .unlocked    (unlocked),
    .bad_code    (bad_code),
    .alarm       (alarm),
    .digit_count (digit_count),
    .tries_left  (tries_left)
  );

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  // Reference model: digits in a queue, remaining-cycle counts as plain integers.
  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_UNLOCK = 3, M_FAIL = 4, M_LOCK = 5;
  int m_mode   = M_IDLE;
  int m_digits[$];
  bit m_over   = 1'b0;
  int m_tries  = MT;
  int m_left   = 0;

  always @(posedge clk) begin : model
    int kd;
    bit kv;
    bit match;
    kv = ($countones(key_pulse) == 1);
    kd = 0;
    for (int i = 0; i < NK; i++) if (key_pulse[i]) kd = i;
    if (reset) begin
      m_mode = M_IDLE; m_digits.delete(); m_over = 0; m_tries = MT; m_left = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (kv) begin
          m_digits.delete(); m_digits.push_back(kd); m_mode = M_ENTRY; m_left = TO;
        end
        M_ENTRY: begin
          if (enter_pulse) m_mode = M_CHECK;
          else if (clear_pulse) begin
            m_digits.delete(); m_over = 0; m_mode = M_IDLE;
          end else if (kv) begin
            if (m_digits.size() == CL) m_over = 1; else m_digits.push_back(kd);
            m_left = TO;
          end else begin
            m_left--;
            if (m_left == 0) begin m_digits.delete(); m_over = 0; m_mode = M_IDLE; end
          end
        end
        M_CHECK: begin
          match = (m_digits.size() == CL) && !m_over;
          if (match)
            for (int i = 0; i < CL; i++)
              if (m_digits[i] != int'(code_in[i*KW +: KW])) match = 0;
          m_digits.delete(); m_over = 0;
          if (match) begin m_mode = M_UNLOCK; m_left = UC; m_tries = MT; end
          else if (m_tries > 1) begin m_tries--; m_mode = M_FAIL; end
          else begin m_tries = 0; m_mode = M_LOCK; m_left = LC; end
        end
        M_FAIL: m_mode = M_IDLE;
        M_UNLOCK: begin
          if (clear_pulse) m_mode = M_IDLE;
          else begin m_left--; if (m_left == 0) m_mode = M_IDLE; end
        end
        M_LOCK: begin
          m_left--;
          if (m_left == 0) begin m_mode = M_IDLE; m_tries = MT; end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("unlocked",    int'(unlocked),    int'(m_mode == M_UNLOCK));
      check("bad_code",    int'(bad_code),    int'(m_mode == M_FAIL));
      check("alarm",       int'(alarm),       int'(m_mode == M_LOCK));
      check("digit_count", int'(digit_count), m_digits.size());
      check("tries_left",  int'(tries_left),  m_tries);
    end
  end

  task automatic step(input logic [NK-1:0] k, input logic e, input logic c);
    key_pulse = k; enter_pulse = e; clear_pulse = c;
    @(negedge clk);
    key_pulse = '0; enter_pulse = 1'b0; clear_pulse = 1'b0;
  endtask

  task automatic key(input int d);
    step(NK'(1 << d), 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_unlocked", int'(unlocked), 0);
    check("rst_tries", int'(tries_left), 3);
    check("rst_count", int'(digit_count), 0);
    check("rst_alarm", int'(alarm), 0);
    reset = 1'b0;

    // Correct code: unlocked two cycles after enter, for ten cycles
    key(0); key(1); key(2); key(3);
    check("t1_count", int'(digit_count), 4);
    step('0, 1'b1, 1'b0);
    check("t1_check_locked", int'(unlocked), 0);
    idle(1);
    check("t1_unlocked", int'(unlocked), 1);
    check("t1_tries", int'(tries_left), 3);
    n = 1;
    repeat (12) begin idle(1); if (unlocked) n++; end
    check("t1_unlock_len", n, 10);

    // Short code
    key(0); key(1); key(2);
    step('0, 1'b1, 1'b0);
    idle(1);
    check("t2_bad", int'(bad_code), 1);
    check("t2_tries", int'(tries_left), 2);
    idle(1);
    check("t2_bad_off", int'(bad_code), 0);

    // Overrun
    key(0); key(1); key(2); key(3); key(3);
    check("t3_count", int'(digit_count), 4);
    step('0, 1'b1, 1'b0);
    idle(1);
    check("t3_bad", int'(bad_code), 1);
    check("t3_tries", int'(tries_left), 1);
    idle(1);

    // Correct code restores tries; clear re-locks at once
    key(0); key(1); key(2); key(3);
    step('0, 1'b1, 1'b0);
    idle(1);
    check("t4_unlocked", int'(unlocked), 1);
    check("t4_tries", int'(tries_left), 3);
    step('0, 1'b0, 1'b1);
    check("t4_relock", int'(unlocked), 0);

    // Three wrong entries -> lockout
    for (int i = 0; i < 2; i++) begin
      key(3); step('0, 1'b1, 1'b0); idle(1);
      check("t5_bad", int'(bad_code), 1);
      idle(1);
    end
    key(3); step('0, 1'b1, 1'b0); idle(1);
    check("t5_alarm", int'(alarm), 1);
    check("t5_tries0", int'(tries_left), 0);
    n = 1;
    for (int i = 0; i < 25; i++) begin
      step(NK'(1 << (i % 4)), (i % 3) == 0, (i % 5) == 0);
      if (alarm) n++;
      check("t5_ignored", int'(digit_count), 0);
    end
    repeat (10) begin idle(1); if (alarm) n++; end
    check("t5_alarm_len", n, 30);
    check("t5_tries_back", int'(tries_left), 3);
    key(0); key(1); key(2); key(3);
    step('0, 1'b1, 1'b0);
    idle(1);
    check("t5_unlock_after", int'(unlocked), 1);
    idle(12);

    // Entry timeout and invalid multi-bit keys
    key(0);
    idle(19);
    check("t6_pre_timeout", int'(digit_count), 1);
    idle(1);
    check("t6_timeout", int'(digit_count), 0);
    step(4'b0011, 1'b0, 1'b0);
    check("t6_multi_idle", int'(digit_count), 0);
    key(1);
    step(4'b0011, 1'b0, 1'b0);
    check("t6_multi_entry", int'(digit_count), 1);
    step(4'b0100, 1'b0, 1'b1);
    check("t6_clear_wins", int'(digit_count), 0);

    // Enter beats key in the same cycle; reset mid-unlock
    key(0); key(1); key(2); key(3);
    step(4'b1000, 1'b1, 1'b1);
    idle(1);
    check("t7_enter_wins", int'(unlocked), 1);
    idle(3);
    reset = 1'b1;
    idle(1);
    check("t7_rst_unlocked", int'(unlocked), 0);
    check("t7_rst_tries", int'(tries_left), 3);
    check("t7_rst_count", int'(digit_count), 0);
    check("t7_rst_alarm", int'(alarm), 0);
    reset = 1'b0;
    idle(3);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
